turkey_crossing_ctrl: RTL and testbench

- Sequencing controller for the turkey-counter datapath.
- Watches the left and right beam sensors and decodes complete crossings into one-cycle inc/dec pulses for the up/down turkey count.
- Drives CE and R of the seconds time counter (8-bit count, saturating at 60), so the counter measures seconds since the last beam activity.
- Raises an idle flag once that time reaches a threshold.

---
 rtl/turkey_pkg.sv | 91 +++++++++
 rtl/beam_sync.sv | 20 ++
 rtl/turkey_crossing_ctrl.sv | 68 ++++++
 tb/tb_turkey_crossing_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/turkey_pkg.sv
// Shared types and constants for the turkey-counter sequencing logic.
// Holds the crossing FSM encoding and its next-state rule.
package turkey_pkg;

  localparam int TC_WIDTH = 8;
  localparam int TC_SAT   = 60;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_L1      = 3'd1,
    S_LB      = 3'd2,
    S_LR      = 3'd3,
    S_R1      = 3'd4,
    S_RB      = 3'd5,
    S_RL      = 3'd6,
    S_WAITCLR = 3'd7
  } state_t;

  // b is {left, right}; unlisted inputs hold the state
  function automatic state_t next_state(
    state_t     s,
    logic [1:0] b
  );
    state_t n;
    n = s;
    case (s)
      S_IDLE: begin
        case (b)
          2'b10:   n = S_L1;
          2'b01:   n = S_R1;
          2'b11:   n = S_WAITCLR;
          default: n = s;
        endcase
      end
      S_L1: begin
        case (b)
          2'b00:   n = S_IDLE;
          2'b11:   n = S_LB;
          2'b01:   n = S_WAITCLR;
          default: n = s;
        endcase
      end
      S_LB: begin
        case (b)
          2'b10:   n = S_L1;
          2'b01:   n = S_LR;
          2'b00:   n = S_WAITCLR;
          default: n = s;
        endcase
      end
      S_LR: begin
        case (b)
          2'b11:   n = S_LB;
          2'b00:   n = S_IDLE;
          2'b10:   n = S_WAITCLR;
          default: n = s;
        endcase
      end
      S_R1: begin
        case (b)
          2'b00:   n = S_IDLE;
          2'b11:   n = S_RB;
          2'b10:   n = S_WAITCLR;
          default: n = s;
        endcase
      end
      S_RB: begin
        case (b)
          2'b01:   n = S_R1;
          2'b10:   n = S_RL;
          2'b00:   n = S_WAITCLR;
          default: n = s;
        endcase
      end
      S_RL: begin
        case (b)
          2'b11:   n = S_RB;
          2'b00:   n = S_IDLE;
          2'b01:   n = S_WAITCLR;
          default: n = s;
        endcase
      end
      S_WAITCLR: begin
        if (b == 2'b00) n = S_IDLE;
      end
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/beam_sync.sv
// Multi-flop synchronizer for the two asynchronous beam levels.
// Output lags the pins by STAGES clocks.
module beam_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic [1:0] d,
  output logic [1:0] q
);

  logic [STAGES-1:0][1:0] ff;

  // shift the beam pair through the synchronizer chain
  always_ff @(posedge clk) begin
    ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/turkey_crossing_ctrl.sv
// Decodes beam crossings into inc/dec pulses and sequences the
// seconds time counter and the inactivity flag.
module turkey_crossing_ctrl
  import turkey_pkg::*;
#(
  parameter int IDLE_SECS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                R,
  input  logic                beam_l,
  input  logic                beam_r,
  input  logic                sec_tick,
  input  logic [TC_WIDTH-1:0] tc_q,
  output logic                tc_ce,
  output logic                tc_r,
  output logic                inc,
  output logic                dec,
  output logic                idle_flag,
  output logic                busy
);

  localparam logic [TC_WIDTH-1:0] IDLE_THR =
    TC_WIDTH'(IDLE_SECS);

  logic [1:0] b;
  state_t     state;
  state_t     nxt;
  logic       clr_q;
  logic       fire_inc;
  logic       fire_dec;

  beam_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .d  ({beam_l, beam_r}),
    .q  (b)
  );

  assign nxt      = next_state(state, b);
  assign fire_inc = (state == S_LR) && (b == 2'b00);
  assign fire_dec = (state == S_RL) && (b == 2'b00);

  // crossing FSM with registered pulse, timer-clear and status outputs
  always_ff @(posedge clk) begin
    if (R) begin
      state     <= S_IDLE;
      inc       <= 1'b0;
      dec       <= 1'b0;
      clr_q     <= 1'b0;
      busy      <= 1'b0;
      idle_flag <= 1'b0;
    end else begin
      state     <= nxt;
      inc       <= fire_inc;
      dec       <= fire_dec;
      clr_q     <= (nxt != S_IDLE) | fire_inc | fire_dec;
      busy      <= (nxt != S_IDLE);
      idle_flag <= (state == S_IDLE) && (tc_q >= IDLE_THR) && !clr_q;
    end
  end

  // the counter saturates itself, so ticks keep flowing while idle
  assign tc_ce = sec_tick & (state == S_IDLE) & ~clr_q & ~R;
  assign tc_r  = R | clr_q;

endmodule

// File: tb/tb_turkey_crossing_ctrl.sv
// Randomized scoreboard bench for turkey_crossing_ctrl with a
// saturating seconds counter closing the tc_q loop.
module tb_turkey_crossing_ctrl;

  localparam int SYNC  = 2;
  localparam int ISECS = 4;

  logic       clk = 1'b0;
  logic       R = 1'b1;
  logic       beam_l = 1'b0;
  logic       beam_r = 1'b0;
  logic       sec_tick = 1'b0;
  logic [7:0] tc_q;
  logic       tc_ce, tc_r, inc, dec, idle_flag, busy;

  turkey_crossing_ctrl #(
    .IDLE_SECS  (ISECS),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk      (clk),
    .R        (R),
    .beam_l   (beam_l),
    .beam_r   (beam_r),
    .sec_tick (sec_tick),
    .tc_q     (tc_q),
    .tc_ce    (tc_ce),
    .tc_r     (tc_r),
    .inc      (inc),
    .dec      (dec),
    .idle_flag(idle_flag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (tc_r) tc_q <= 8'd0;
    else if (tc_ce && tc_q < 8'd60) tc_q <= tc_q + 8'd1;
  end

  int n_pass = 0;
  int n_tot  = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  typedef struct {
    bit     is_inc;
    longint cyc;
  } ev_t;
  ev_t exq[$];

  // Reference: a crossing is a walk over beam positions
  // 10=1, 11=2, 01=3 that starts from 00, moves one step at a
  // time, and returns to 00 from the far side.
  logic [1:0] m_cur = 2'b00;
  int         m_org = 0;
  bit         m_bad = 1'b0;
  longint     drive_cyc = 0;

  function automatic int pos_of(logic [1:0] p);
    case (p)
      2'b10:   return 1;
      2'b11:   return 2;
      2'b01:   return 3;
      default: return 0;
    endcase
  endfunction

  function automatic void model(logic [1:0] p);
    int d;
    ev_t e;
    if (p == m_cur) return;
    if (m_cur == 2'b00) begin
      m_bad = (p == 2'b11);
      m_org = (p == 2'b10) ? 1 : (p == 2'b01) ? 2 : 0;
    end else if (p == 2'b00) begin
      e.cyc = drive_cyc + SYNC + 1;
      if (!m_bad && m_org == 1 && pos_of(m_cur) == 3) begin
        e.is_inc = 1'b1;
        exq.push_back(e);
      end
      if (!m_bad && m_org == 2 && pos_of(m_cur) == 1) begin
        e.is_inc = 1'b0;
        exq.push_back(e);
      end
      m_bad = 1'b0;
      m_org = 0;
    end else begin
      d = pos_of(p) - pos_of(m_cur);
      if (d != 1 && d != -1) m_bad = 1'b1;
    end
    m_cur = p;
  endfunction

  int cnt_inc = 0;
  int cnt_dec = 0;
  bit prev_pulse = 1'b0;
  ev_t mev;

  always @(negedge clk) begin
    if (!R) begin
      if (inc || dec) begin
        chk("pulse_excl", longint'(inc && dec), 0);
        chk("pulse_gap", longint'(prev_pulse), 0);
        chk("pulse_expected", longint'(exq.size() > 0), 1);
        if (exq.size() > 0) begin
          mev = exq.pop_front();
          chk("pulse_kind", longint'(inc), longint'(mev.is_inc));
          chk("pulse_cycle", cyc, mev.cyc);
        end
      end
      if (busy) chk("tc_r_while_busy", longint'(tc_r), 1);
      if (tc_ce) chk("tc_ce_only_idle", longint'(busy), 0);
    end
    prev_pulse <= inc || dec;
    cnt_inc    <= cnt_inc + int'(inc);
    cnt_dec    <= cnt_dec + int'(dec);
  end

  bit tick_rand = 1'b0;

  task automatic hold(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      sec_tick = tick_rand && ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic set_beam(logic [1:0] p, int n);
    @(posedge clk);
    #1;
    {beam_l, beam_r} = p;
    sec_tick = 1'b0;
    drive_cyc = cyc;
    model(p);
    hold(n - 1);
  endtask

  task automatic give_ticks(int n);
    repeat (n) begin
      @(posedge clk);
      #1 sec_tick = 1'b1;
      @(posedge clk);
      #1 sec_tick = 1'b0;
    end
  endtask

  int         b_inc, b_dec;
  logic [1:0] ring[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int         ri;
  logic [1:0] rp;

  initial begin
    R = 1'b1;
    sec_tick = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_inc", longint'(inc), 0);
    chk("rst_dec", longint'(dec), 0);
    chk("rst_idle", longint'(idle_flag), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_tc_ce", longint'(tc_ce), 0);
    chk("rst_tc_r", longint'(tc_r), 1);
    @(posedge clk);
    #1;
    R = 1'b0;
    sec_tick = 1'b0;

    give_ticks(3);
    hold(2);
    chk("idle_tc3", longint'(tc_q), 3);
    chk("idle_before_thr", longint'(idle_flag), 0);
    give_ticks(1);
    hold(2);
    chk("idle_tc4", longint'(tc_q), 4);
    chk("idle_at_thr", longint'(idle_flag), 1);
    give_ticks(66);
    hold(2);
    chk("idle_sat", longint'(tc_q), 60);
    chk("idle_sat_flag", longint'(idle_flag), 1);
    @(posedge clk);
    #1;
    {beam_l, beam_r} = 2'b10;
    drive_cyc = cyc;
    model(2'b10);
    for (int k = 0; k < SYNC + 2; k++) begin
      @(posedge clk);
      #1;
      if (!idle_flag) break;
    end
    chk("idle_clear", longint'(idle_flag), 0);
    chk("idle_tc_zero", longint'(tc_q), 0);
    hold(3);
    set_beam(2'b00, 8);

    b_inc = cnt_inc; b_dec = cnt_dec;
    set_beam(2'b10, 5); set_beam(2'b11, 5);
    set_beam(2'b01, 5); set_beam(2'b00, 8);
    chk("lr_inc", cnt_inc - b_inc, 1);
    chk("lr_dec", cnt_dec - b_dec, 0);
    chk("lr_tc_zero", longint'(tc_q), 0);
    give_ticks(2);
    hold(2);
    chk("lr_tc_restart", longint'(tc_q), 2);

    b_inc = cnt_inc; b_dec = cnt_dec;
    repeat (2) begin
      set_beam(2'b01, 5); set_beam(2'b11, 5);
      set_beam(2'b10, 5); set_beam(2'b00, 5);
    end
    hold(3);
    chk("rl_dec2", cnt_dec - b_dec, 2);
    chk("rl_inc0", cnt_inc - b_inc, 0);

    b_inc = cnt_inc; b_dec = cnt_dec;
    set_beam(2'b10, 5); set_beam(2'b00, 8);
    chk("retreat_none", (cnt_inc - b_inc) + (cnt_dec - b_dec), 0);
    chk("retreat_idle", longint'(busy), 0);

    b_inc = cnt_inc;
    set_beam(2'b10, 5); set_beam(2'b11, 5); set_beam(2'b10, 5);
    set_beam(2'b11, 5); set_beam(2'b01, 5); set_beam(2'b00, 8);
    chk("backtrack_inc", cnt_inc - b_inc, 1);

    b_inc = cnt_inc; b_dec = cnt_dec;
    set_beam(2'b11, 5); set_beam(2'b00, 8);
    set_beam(2'b10, 5); set_beam(2'b01, 5); set_beam(2'b00, 8);
    chk("invalid_none", (cnt_inc - b_inc) + (cnt_dec - b_dec), 0);

    b_inc = cnt_inc; b_dec = cnt_dec;
    set_beam(2'b10, 5); set_beam(2'b11, 5);
    @(posedge clk);
    #1 R = 1'b1;
    m_bad = 1'b1;
    m_org = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rmid_busy", longint'(busy), 0);
    chk("rmid_inc", longint'(inc), 0);
    chk("rmid_dec", longint'(dec), 0);
    chk("rmid_tc_r", longint'(tc_r), 1);
    @(posedge clk);
    #1 R = 1'b0;
    set_beam(2'b01, 5); set_beam(2'b00, 8);
    chk("rmid_none", (cnt_inc - b_inc) + (cnt_dec - b_dec), 0);

    tick_rand = 1'b1;
    ri = 0;
    repeat (300) begin
      if ($urandom_range(0, 3) != 0) begin
        ri = ($urandom_range(0, 1) == 1) ? (ri + 1) % 4 : (ri + 3) % 4;
      end else begin
        ri = int'($urandom_range(0, 3));
      end
      rp = ring[ri];
      set_beam(rp, int'($urandom_range(3, 8)));
    end
    tick_rand = 1'b0;
    set_beam(2'b00, 12);
    chk("queue_drained", longint'(exq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
